// File: rtl/spi_reg_bank.sv
// SPI slave register bank: 24-bit frames (cmd[7:0] + data[15:0]) write a 32x16 register file.
// Optional readback of regs over spi_miso is enabled by defining SPI_REG_READBACK_EN.
module spi_reg_bank #(
  parameter int SYNC_STAGES = 2,
  parameter int CLK_DIV_MIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [15:0] regs [32],
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic        frame_err,
  output logic [1:0]  fsm_state
);

  if (SYNC_STAGES < 2 || CLK_DIV_MIN < 1) begin : g_param_check
    $error("spi_reg_bank: SYNC_STAGES must be >= 2 and CLK_DIV_MIN >= 1");
  end

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic        sclk_prev, cs_prev;
  logic        sclk_s, cs_s, mosi_s;
  logic        sclk_rise, cs_fall, cs_rise;
  logic [4:0]  bit_cnt;
  logic [14:0] shift_reg;
  logic [15:0] shift_in;
  logic [7:0]  frame_cmd;

  logic shift_en, cnt_clr, abort, cmd_done, frame_done;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign shift_in  = {shift_reg, mosi_s};
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A chip-select fall restarts the frame from any state; an abort is flagged only mid-frame.
  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    cnt_clr    = 1'b0;
    abort      = 1'b0;
    cmd_done   = 1'b0;
    frame_done = 1'b0;
    if (cs_fall) begin
      next_state = CMD;
      cnt_clr    = 1'b1;
      abort      = (state == CMD) || (state == DATA);
    end else begin
      case (state)
        CMD, DATA: begin
          if (cs_rise) begin
            next_state = IDLE;
            abort      = 1'b1;
          end else if (sclk_rise) begin
            shift_en = 1'b1;
            if (state == CMD && bit_cnt == 5'd7) begin
              next_state = DATA;
              cmd_done   = 1'b1;
            end
            if (state == DATA && bit_cnt == 5'd23) begin
              next_state = DONE;
              frame_done = 1'b1;
            end
          end
        end
        DONE:    if (cs_rise) next_state = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      frame_cmd <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      wr_strobe <= 1'b0;
      frame_err <= abort;
      if (cnt_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 5'd1;
      if (shift_en) shift_reg <= shift_in[14:0];
      if (cmd_done) frame_cmd <= shift_in[7:0];
      // Reserved command bits reject the frame instead of writing.
      if (frame_done) begin
        if (frame_cmd[6:5] != 2'b00) begin
          frame_err <= 1'b1;
        end else if (frame_cmd[7]) begin
          regs[frame_cmd[4:0]] <= shift_in;
          wr_strobe            <= 1'b1;
          wr_addr              <= frame_cmd[4:0];
        end
      end
    end
  end

`ifdef SPI_REG_READBACK_EN
  logic        sclk_fall;
  logic [15:0] miso_sr;

  assign sclk_fall = ~sclk_s & sclk_prev;

  // The loaded MSB is held through the bit-9 rising edge, so shifting starts after it.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      miso_sr <= '0;
    end else if (cmd_done && !shift_in[7]) begin
      miso_sr <= regs[shift_in[4:0]];
    end else if (sclk_fall && state == DATA && bit_cnt >= 5'd9 && !frame_cmd[7]) begin
      miso_sr <= {miso_sr[14:0], 1'b0};
    end
  end

  assign spi_miso = ~spi_cs_n & miso_sr[15];
`else
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed and random SPI frames scored against a register-file model.
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso;
  logic [15:0] regs [32];
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic        frame_err;
  logic [1:0]  fsm_state;

  // clock / reset
  always #5 clk = ~clk;

  spi_reg_bank dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .frame_err(frame_err), .fsm_state(fsm_state)
  );

  // model and scoreboard
  logic [15:0] model [32];
  logic [20:0] exp_q[$];
  int err_exp  = 0;
  int n_cmp    = 0;
  int n_bad    = 0;
  int wr_count = 0;
  bit active   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_q.delete();
        err_exp = 0;
      end else begin
        if (wr_strobe) begin
          logic [20:0] e;
          wr_count++;
          if (exp_q.size() == 0) begin
            check("wr_strobe_unexpected", {31'd0, wr_strobe}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", {27'd0, wr_addr}, {27'd0, e[20:16]});
            model[e[20:16]] = e[15:0];
          end
        end
        if (frame_err) begin
          if (err_exp == 0) check("frame_err_unexpected", {31'd0, frame_err}, 32'd0);
          else err_exp--;
        end
        begin
          int bad_idx;
          bad_idx = -1;
          for (int i = 0; i < 32; i++)
            if (regs[i] !== model[i] && bad_idx < 0) bad_idx = i;
          if (bad_idx >= 0) check($sformatf("regs[%0d]", bad_idx), {16'd0, regs[bad_idx]}, {16'd0, model[bad_idx]});
          else check("regs", {16'd0, regs[0]}, {16'd0, model[0]});
        end
`ifndef SPI_REG_READBACK_EN
        check("miso_const", {31'd0, spi_miso}, 32'd0);
`endif
      end
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [7:0] cmd, input logic [15:0] data, input int nbits);
    if (nbits < 24)               err_exp++;
    else if (cmd[6:5] != 2'b00)   err_exp++;
    else if (cmd[7])              exp_q.push_back({cmd[4:0], data});
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] data, input int nbits,
                           input int extra, input int rst_bit, output logic [15:0] miso_bits);
    logic [23:0] word;
    word      = {cmd, data};
    miso_bits = '0;
    spi_cs_n  = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = word[23-i];
      spi_sclk = 1'b0;
      wait_clk(4);
      if (i >= 8) miso_bits = {miso_bits[14:0], spi_miso};
      if (i == rst_bit) begin
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
      end
      spi_sclk = 1'b1;
      wait_clk(4);
    end
    spi_sclk = 1'b0;
    for (int j = 0; j < extra; j++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      wait_clk(4);
      spi_sclk = 1'b1;
      wait_clk(4);
      spi_sclk = 1'b0;
    end
    wait_clk(4);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(12);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] data, input int nbits,
                           input int extra, output logic [15:0] miso_bits);
    expect_frame(cmd, data, nbits);
    spi_frame(cmd, data, nbits, extra, -1, miso_bits);
    check("pending_wr", exp_q.size(), 32'd0);
    check("pending_err", err_exp, 32'd0);
    check("miso_cs_high", {31'd0, spi_miso}, 32'd0);
  endtask

  // main sequence
  initial begin
    logic [15:0] mb;
    logic [15:0] exp_rb;
    int wc0;
    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    active = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    check("rst_reg9", {16'd0, regs[9]}, 32'd0);

    wc0 = wr_count;
    run_frame(8'h82, 16'h1234, 24, 0, mb);
    check("wr_reg2", {16'd0, regs[2]}, 32'h1234);
    check("wr_reg2_pulses", wr_count - wc0, 32'd1);

    wc0 = wr_count;
    run_frame(8'h8E, 16'hBEEF, 20, 0, mb);
    check("abort_reg14", {16'd0, regs[14]}, 32'd0);
    check("abort_pulses", wr_count - wc0, 32'd0);

    wc0 = wr_count;
    run_frame(8'hA3, 16'hFFFF, 24, 0, mb);
    check("reserved_reg3", {16'd0, regs[3]}, 32'd0);
    check("reserved_pulses", wr_count - wc0, 32'd0);

    wc0 = wr_count;
    run_frame(8'h8F, 16'h0002, 24, 8, mb);
    check("extra_reg15", {16'd0, regs[15]}, 32'h0002);
    check("extra_pulses", wr_count - wc0, 32'd1);

    wc0 = wr_count;
    spi_frame(8'h81, 16'h00FF, 24, 0, 14, mb);
    check("rst_mid_reg1", {16'd0, regs[1]}, 32'd0);
    check("rst_mid_reg2", {16'd0, regs[2]}, 32'd0);
    check("rst_mid_reg15", {16'd0, regs[15]}, 32'd0);
    check("rst_mid_pulses", wr_count - wc0, 32'd0);
    run_frame(8'h81, 16'h0010, 24, 0, mb);
    check("after_rst_reg1", {16'd0, regs[1]}, 32'h0010);

    run_frame(8'h87, 16'hA5C3, 24, 0, mb);
    run_frame(8'h07, 16'h0000, 24, 0, mb);
`ifdef SPI_REG_READBACK_EN
    check("readback_7", {16'd0, mb}, 32'hA5C3);
`else
    check("readback_off", {16'd0, mb}, 32'd0);
`endif

    for (int k = 0; k < 40; k++) begin
      logic [7:0]  cmd;
      logic [15:0] data;
      int nbits, extra;
      cmd   = 8'($urandom_range(0, 255));
      data  = 16'($urandom);
      if ($urandom_range(0, 3) != 0) cmd[6:5] = 2'b00;
      nbits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 23) : 24;
      extra = (nbits == 24) ? $urandom_range(0, 3) : 0;
      exp_rb = model[cmd[4:0]];
      run_frame(cmd, data, nbits, extra, mb);
`ifdef SPI_REG_READBACK_EN
      if (nbits == 24 && !cmd[7] && cmd[6:5] == 2'b00) check("readback_rand", {16'd0, mb}, {16'd0, exp_rb});
`else
      check("readback_rand_off", {16'd0, mb}, 32'd0);
`endif
    end

    check("final_pending_wr", exp_q.size(), 32'd0);
    check("final_pending_err", err_exp, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on sclk, cs_n and mosi (minimum 2).
REQ-002 Parameter CLK_DIV_MIN, default 4: documented minimum clk/sclk ratio; informational only, no logic depends on it.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 spi_sclk  input  1  SPI clock from the front-end MCU; asynchronous to clk; mode 0.
REQ-006 spi_cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 spi_mosi  input  1  SPI data in, MSB first.
REQ-008 spi_miso  output  1  SPI data out; used only for readback.
REQ-009 regs  output  32x16 array  register file consumed by the decode stage (regs[0]..regs[31]).
REQ-010 wr_strobe  output  1  one-clk pulse when a register write commits.
REQ-011 wr_addr  output  5  address of the last committed write; valid while wr_strobe is high.
REQ-012 frame_err  output  1  one-clk pulse when a frame is aborted or rejected.

Function
REQ-013 spi_sclk, spi_cs_n and spi_mosi shall each pass through SYNC_STAGES flops before use; sclk edges are detected from the last two synchronized samples.
REQ-014 A frame is 24 bits: cmd[7:0] followed by data[15:0]; cmd[7]=1 means write and cmd[7]=0 means read; cmd[6:5] are reserved; cmd[4:0] is the address.
REQ-015 FSM states: IDLE, CMD, DATA, DONE; rst forces IDLE.
REQ-016 IDLE -> CMD on a synchronized cs_n falling edge; the bit counter clears to 0.
REQ-017 In CMD and DATA, mosi is sampled on each detected sclk rising edge into a shift register, MSB first; the bit counter increments on each such edge.
REQ-018 CMD -> DATA after bit 8; cmd is latched at that point.
REQ-019 DATA -> DONE after bit 24.
REQ-020 Write commit: in the clk cycle after the 24th rising edge, if cmd[7]=1 and cmd[6:5]=0, then regs[addr] <= data and wr_strobe=1 for exactly one cycle, with wr_addr=addr.
REQ-021 If cmd[6:5]!=0, no register changes and frame_err pulses once at bit 24.
REQ-022 DONE: further sclk edges are ignored (no shift, no commit) until cs_n rises; then the FSM returns to IDLE.
REQ-023 A cs_n rise in CMD or DATA aborts the frame: no write, frame_err pulses once, FSM goes to IDLE.
REQ-024 Only one register is written per cs_n assertion; back-to-back frames require cs_n to rise between them.
REQ-025 A read command (cmd[7]=0) shall never modify regs.
REQ-026 regs outputs are registered and change only on a write commit or on rst.
REQ-027 A cs_n falling edge seen in any state other than IDLE is treated as an abort followed by a new frame start.

Reset
REQ-028 On rst, the following all clear to 0 on the next clk edge: all regs[0..31], wr_strobe, wr_addr, frame_err, spi_miso, the shift register, the bit counter and the synchronizer flops; the FSM goes to IDLE.
REQ-029 When rst asserts mid-frame, the frame is discarded without a commit and without a frame_err pulse; the FSM waits for a fresh cs_n falling edge after rst releases.
REQ-030 regs[9] resets to 0; the step==0 -> 1 substitution is handled by the decode stage, not here.

Configuration
REQ-031 The macro SPI_REG_READBACK_EN controls readback; the default is undefined.
REQ-032 With SPI_REG_READBACK_EN defined, a read command behaves as follows:
- At bit 8, regs[addr] is loaded into a 16-bit output shift register.
- Its MSB drives spi_miso, and each subsequent detected sclk falling edge shifts it left.
- spi_miso is 0 whenever cs_n is high.
REQ-033 With SPI_REG_READBACK_EN undefined, spi_miso is constant 0, read commands are consumed silently, and no readback logic is synthesized.

Verification
REQ-034 Write 0x82 then 0x1234 (sclk = clk/8) -> regs[2]=0x1234; one wr_strobe pulse with wr_addr=2; frame_err stays 0.
REQ-035 Send 0x8E, then raise cs_n after 12 data bits -> regs[14] unchanged, frame_err pulses once, wr_strobe stays 0.
REQ-036 Send cmd 0xA3 (reserved bits set) with data 0xFFFF -> all regs unchanged, frame_err pulses once at bit 24.
REQ-037 Write 0x8F/0x0002, then clock 8 extra sclk cycles before cs_n rises -> regs[15]=0x0002 and exactly one wr_strobe pulse.
REQ-038 Assert rst during the data phase of write 0x81/0x00FF -> all regs are 0; a following complete write 0x81/0x0010 gives regs[1]=0x0010.
REQ-039 With SPI_REG_READBACK_EN defined, write 0x87/0xA5C3, then send read 0x07 -> spi_miso shifts out 0xA5C3 MSB first on data bits 9..24; with the macro undefined, spi_miso stays 0.
